// File: rtl/nrdiv_pkg.sv
// Shared types for the sequential non-restoring divider: FSM state encoding
// and the iteration-counter width helper.
package nrdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter runs DW-1 down to 0, so it needs $clog2(DW) bits (DW >= 2).
  function automatic int cnt_w(input int dw);
    return $clog2(dw);
  endfunction

endpackage

// File: rtl/seq_nrdiv_if.sv
// Operand/result handshake bundle for seq_nrdiv. The is_signed operand only
// exists when NRDIV_SIGNED_EN is defined.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1; the producer holds valid and data steady until then, and the
// consumer may change ready freely.
interface seq_nrdiv_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;
`ifdef NRDIV_SIGNED_EN
  logic          is_signed;

  modport master (
    output in_valid, dividend, divisor, is_signed, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );
  modport slave (
    input  in_valid, dividend, divisor, is_signed, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
`else
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
`endif
endinterface

// File: rtl/nrdiv_step.sv
// One non-restoring division iteration: shift the partial remainder, bring in
// a dividend bit, then add or subtract the divisor depending on its sign.
module nrdiv_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   pr,
  input  logic [VW-1:0] divisor,
  input  logic          bit_in,
  output logic [VW:0]   pr_next,
  output logic          q_bit
);

  // One extra bit of headroom holds 2*pr+bit before the divisor pulls it back
  // into [-divisor, divisor).
  logic [VW+1:0] shifted;
  logic [VW+1:0] dext;
  logic [VW+1:0] sum;

  always_comb begin
    shifted = {pr, bit_in};
    dext    = {2'b00, divisor};
    sum     = pr[VW] ? (shifted + dext) : (shifted - dext);
    pr_next = sum[VW:0];
    q_bit   = ~sum[VW+1];
  end

endmodule

// File: rtl/seq_nrdiv.sv
// Sequential non-restoring divider, one quotient bit per cycle.
// Define NRDIV_SIGNED_EN to add the is_signed operand (two's-complement,
// truncating division); latency is the same in both builds.
module seq_nrdiv
  import nrdiv_pkg::*;
#(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic        clk,
  input  logic        rst,
  seq_nrdiv_if.slave  bus,
  output state_t      state_dbg
);

  localparam int CW = cnt_w(DW);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [VW:0]   pr;
  logic [VW:0]   pr_next;
  logic [DW-1:0] acc;
  logic [VW-1:0] dvs;
  logic          q_bit;
  logic          neg_q;
  logic          neg_r;
  logic [DW-1:0] quot_r;
  logic [VW-1:0] rem_r;
  logic          dbz_r;
  logic          out_valid_r;
  logic          in_ready_r;

  logic          dend_neg;
  logic          dvs_neg;
  logic [DW-1:0] dend_mag;
  logic [VW-1:0] dvs_mag;
  logic [VW-1:0] fix_rem;

`ifdef NRDIV_SIGNED_EN
  // Signed operands are divided as magnitudes; signs are reapplied in FIX.
  always_comb begin
    dend_neg = bus.is_signed & bus.dividend[DW-1];
    dvs_neg  = bus.is_signed & bus.divisor[VW-1];
    dend_mag = dend_neg ? -bus.dividend : bus.dividend;
    dvs_mag  = dvs_neg ? -bus.divisor : bus.divisor;
  end
`else
  always_comb begin
    dend_neg = 1'b0;
    dvs_neg  = 1'b0;
    dend_mag = bus.dividend;
    dvs_mag  = bus.divisor;
  end
`endif

  // A negative final partial remainder is off by exactly one divisor.
  always_comb begin
    fix_rem = pr[VW] ? (pr[VW-1:0] + dvs) : pr[VW-1:0];
  end

  nrdiv_step #(.VW(VW)) u_step (
    .pr      (pr),
    .divisor (dvs),
    .bit_in  (acc[DW-1]),
    .pr_next (pr_next),
    .q_bit   (q_bit)
  );

  // acc starts as the dividend and fills with quotient bits as it shifts out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pr          <= '0;
      acc         <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quot_r      <= '0;
      rem_r       <= '0;
      dbz_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            in_ready_r <= 1'b0;
            if (bus.divisor == '0) begin
              quot_r      <= '1;
              rem_r       <= bus.dividend[VW-1:0];
              dbz_r       <= 1'b1;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end else begin
              acc   <= dend_mag;
              dvs   <= dvs_mag;
              neg_q <= dend_neg ^ dvs_neg;
              neg_r <= dend_neg;
              pr    <= '0;
              cnt   <= CW'(DW - 1);
              dbz_r <= 1'b0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          pr  <= pr_next;
          acc <= {acc[DW-2:0], q_bit};
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          quot_r      <= neg_q ? -acc : acc;
          rem_r       <= neg_r ? -fix_rem : fix_rem;
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
  assign state_dbg       = state;

endmodule

// File: tb/tb_seq_nrdiv.sv
// Self-checking bench for seq_nrdiv (DW=8, VW=4): directed vectors, a
// reference model built on plain integer division, and a result scoreboard.
module tb_seq_nrdiv;
  import nrdiv_pkg::*;

  localparam int DW = 8;
  localparam int VW = 4;
  localparam int W  = 1 + DW + VW;

  logic   clk = 1'b0;
  logic   rst;
  state_t state_dbg;

  seq_nrdiv_if #(.DW(DW), .VW(VW)) bus ();

  seq_nrdiv #(.DW(DW), .VW(VW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {div_by_zero, quotient, remainder} from plain integer arithmetic.
  function automatic logic [W-1:0] model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                         input bit sgn);
    int sa, sb, q, r;
    logic [31:0] qv, rv;
    if (b == '0) return {1'b1, {DW{1'b1}}, a[VW-1:0]};
    if (sgn) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {1'b0, qv[DW-1:0], rv[VW-1:0]};
  endfunction

  // Compare process: every cycle a result is presented it must match the
  // oldest expected entry; the entry retires on the output handshake.
  always @(negedge clk) begin
    #1;
    if (rst === 1'b0 && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        check("result", 32'({bus.div_by_zero, bus.quotient, bus.remainder}), 32'(exp_q[0]));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit sgn,
                        input int hold);
    int lat;
    int exp_lat;
    exp_lat = (b == '0) ? 1 : DW + 2;
    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
`ifdef NRDIV_SIGNED_EN
    bus.is_signed = sgn;
`endif
    exp_q.push_back(model(a, b, sgn));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.dividend = DW'($urandom);
    bus.divisor  = VW'($urandom);
`ifdef NRDIV_SIGNED_EN
    bus.is_signed = 1'($urandom);
`endif
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    check("in_ready_hs_cycle", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
    check("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic reset_mid_calc();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 4'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("state_calc4", 32'(state_dbg), 32'(CALC));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    for (int i = 0; i < 12; i++) begin
      check("rst_no_out_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
`ifdef NRDIV_SIGNED_EN
    bus.is_signed = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_outputs", 32'({bus.div_by_zero, bus.quotient, bus.remainder}), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;

    // Hand-computed pins on the model itself.
    check("model_100_7", 32'(model(8'd100, 4'd7, 1'b0)), 32'({1'b0, 8'd14, 4'd2}));
    check("model_255_1", 32'(model(8'd255, 4'd1, 1'b0)), 32'({1'b0, 8'd255, 4'd0}));
    check("model_5_15", 32'(model(8'd5, 4'd15, 1'b0)), 32'({1'b0, 8'd0, 4'd5}));
    check("model_5a_0", 32'(model(8'h5A, 4'd0, 1'b0)), 32'({1'b1, 8'hFF, 4'hA}));
    check("model_m100_7", 32'(model(8'h9C, 4'd7, 1'b1)), 32'({1'b0, 8'hF2, 4'hE}));
    check("model_m128_m1", 32'(model(8'h80, 4'hF, 1'b1)), 32'({1'b0, 8'h80, 4'h0}));

    run_op(8'd100, 4'd7,  1'b0, 0);
    run_op(8'd255, 4'd1,  1'b0, 0);
    run_op(8'd5,   4'd15, 1'b0, 0);
    run_op(8'h5A,  4'd0,  1'b0, 0);
    run_op(8'd100, 4'd7,  1'b0, 5);
    run_op(8'd200, 4'd13, 1'b0, 1);
    run_op(8'd0,   4'd9,  1'b0, 0);
    run_op(8'd7,   4'd3,  1'b0, 2);
    run_op(8'd156, 4'd7,  1'b0, 0);

    reset_mid_calc();
    run_op(8'd100, 4'd7, 1'b0, 0);

`ifdef NRDIV_SIGNED_EN
    run_op(8'h9C, 4'd7, 1'b1, 0);
    run_op(8'h80, 4'hF, 1'b1, 0);
    run_op(8'd100, 4'hD, 1'b1, 0);
    run_op(8'hF9, 4'd2, 1'b1, 0);
    run_op(8'h9C, 4'd7, 1'b0, 0);
    run_op(8'h9C, 4'd0, 1'b1, 0);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
